ifetch_ctrl: RTL
================

# ifetch_ctrl

Dual-issue instruction-fetch sequencer for the 64-word instruction memory. It first loads a program into the memory from a valid/ready byte-agnostic word stream, then generates paired read addresses (pc, pc+1) every cycle. It returns instruction pairs to decode with valid/ready backpressure and accepts branch redirects. It sits between the loader/debug port, the instruction memory, and the decode stage.

## Interface
- MEM_SIZE, 64, instruction memory depth in 32-bit words; addresses are word indices
- RESET_PC, 0, first fetch address after load completes
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- load_valid  in  1  program word present
- load_data  in  32  program word
- load_ready  out  1  word accepted when load_valid && load_ready
- load_done  in  1  end-of-program pulse
- redirect_valid  in  1  redirect fetch to redirect_pc
- redirect_pc  in  32  new word address
- mem_enable  out  1  memory read enable (registered read, 1-cycle latency)
- mem_read_address1 / mem_read_address2  out  32  pc / pc+1
- mem_instruction1 / mem_instruction2  in  32  memory read data
- mem_write_enable  out  1  memory write strobe
- mem_write_address  out  32  load word index
- mem_write_data  out  32  load word
- out_valid  out  1  instruction pair valid
- out_ready  in  1  decode accepts pair
- out_pc  out  32  address of out_instr1
- out_instr1 / out_instr2  out  32  instructions at out_pc / out_pc+1
- out_valid2  out  1  second slot valid (out_pc+1 < MEM_SIZE)

## Operation
- States: LOAD, FETCH, END. Reset -> LOAD; pc=RESET_PC, load_cnt=0, rsp_valid=0.
- Reset values: all outputs 0 while reset asserted (including load_ready).
- LOAD: load_ready = (load_cnt < MEM_SIZE). Accepted beat: mem_write_enable=1, mem_write_address=load_cnt, mem_write_data=load_data, load_cnt++ (combinational pass-through, same cycle). Beats when load_cnt==MEM_SIZE are not accepted. load_done -> FETCH next cycle; beat accepted in same cycle as load_done is still written. redirect_valid ignored in LOAD.
- FETCH issue condition: pc < MEM_SIZE, !redirect_valid, !(out_valid && !out_ready). On issue: mem_enable=1, addresses pc/pc+1, rsp_pc<=pc, rsp_valid<=1, pc<=pc+2. No issue: mem_enable=0 (memory holds its output), rsp_valid<=0 unless stalled.
- out_valid = rsp_valid in FETCH/END; out_instr1/2 driven directly from mem_instruction1/2; out_pc=rsp_pc; out_valid2 = rsp_pc+1 < MEM_SIZE.
- Stall: out_valid && !out_ready holds rsp_valid, rsp_pc, pc; mem_enable=0 so data is stable.
- pc >= MEM_SIZE after advance -> END; in-flight pair is still delivered. END issues nothing.
- Redirect (FETCH or END): rsp_valid<=0 (in-flight/stalled pair dropped), pc<=redirect_pc, state<=FETCH if redirect_pc < MEM_SIZE else END. Redirect beats a simultaneous stall or issue.
- Reset mid-operation: returns to LOAD, load_cnt=0; memory contents untouched by this block.

## Timing
- Load write: same cycle as accepted beat.
- Fetch latency: issue in cycle N -> out_valid in N+1. Throughput one pair/cycle with out_ready=1.
- First issue: first cycle in FETCH (cycle after load_done).
- Redirect in cycle N -> issue of redirect_pc in N+1, out_valid in N+2; out_valid=0 in N+1.

## Configuration
- IFETCH_LOADER_EN defined: LOAD state and load port active as above.
- Undefined: reset goes directly to FETCH at RESET_PC; load_ready=0, mem_write_enable/address/data=0; load_valid/load_done ignored.

## Test plan
- Load 0x11,0x22,0x33,0x44 then load_done -> writes to addresses 0..3 in order; FETCH next cycle; out pairs (0:0x11,0x22),(2:0x33,0x44) on consecutive cycles.
- out_ready=0 for 3 cycles at pc=2 pair -> out_valid held, out_pc=2, data stable, mem_enable=0; resumes with pc=4 pair one cycle after out_ready=1.
- Redirect to 10 while pair at 4 stalled -> pair 4 dropped, out_valid=0 one cycle, then out_pc=10.
- MEM_SIZE=64, redirect to 63 -> one pair out_pc=63, out_valid2=0, state END, no further out_valid until redirect.
- redirect_pc=64 -> END, mem_enable stays 0, out_valid=0.
- 65 load beats -> only 64 accepted (load_ready low on 65th); reset mid-load -> load_cnt restarts at 0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: dual-issue instruction-fetch sequencer for a 64-word
// instruction memory. An optional loader writes the program through a
// valid/ready word stream. The sequencer then issues paired reads (pc, pc+1)
// and hands instruction pairs to decode with valid/ready backpressure and
// branch redirects.
// Optional feature macro: IFETCH_LOADER_EN (LOAD state and program-load port).
module ifetch_ctrl #(
  parameter int unsigned MEM_SIZE = 64,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        load_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_enable,
  output logic [31:0] mem_read_address1,
  output logic [31:0] mem_read_address2,
  input  logic [31:0] mem_instruction1,
  input  logic [31:0] mem_instruction2,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr1,
  output logic [31:0] out_instr2,
  output logic        out_valid2
);

  typedef enum logic [1:0] {S_LOAD, S_FETCH, S_END} state_t;

  localparam logic [31:0] W_MEM_SIZE = 32'(MEM_SIZE);
  // A reset PC outside the memory has nothing to fetch.
  localparam state_t S_RUN = (RESET_PC < W_MEM_SIZE) ? S_FETCH : S_END;
`ifdef IFETCH_LOADER_EN
  localparam state_t S_BOOT = S_LOAD;
`else
  localparam state_t S_BOOT = S_RUN;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_rsp_pc;
  logic        r_rsp_valid;

  logic        w_running;
  logic        w_redirect;
  logic        w_stall;
  logic        w_issue;
  logic [31:0] w_pc_adv;
  logic [31:0] w_pc_next;

  assign w_running  = (r_state == S_FETCH) || (r_state == S_END);
  assign w_redirect = w_running && redirect_valid;
  // The presented pair is refused by decode: freeze pc, response and memory.
  assign w_stall    = w_running && r_rsp_valid && !out_ready;
  assign w_issue    = (r_state == S_FETCH) && (r_pc < W_MEM_SIZE) &&
                      !redirect_valid && !w_stall;
  assign w_pc_adv   = r_pc + 32'd2;
  assign w_pc_next  = r_pc + 32'd1;

`ifdef IFETCH_LOADER_EN
  localparam int unsigned CW = $clog2(MEM_SIZE + 1);
  localparam logic [CW-1:0] W_LOAD_MAX = CW'(MEM_SIZE);

  logic [CW-1:0] r_load_cnt;
  logic          w_load_room;
  logic          w_load_acc;

  assign w_load_room = (r_state == S_LOAD) && (r_load_cnt < W_LOAD_MAX);
  assign w_load_acc  = w_load_room && load_valid;

  // Count accepted program words; reset restarts the load at word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_cnt <= '0;
    end else if (w_load_acc) begin
      r_load_cnt <= r_load_cnt + CW'(1);
    end
  end
`else
  logic w_unused_load;
  assign w_unused_load = &{1'b0, load_valid, load_done, load_data};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: load completion, redirects, and running off the end.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
`ifdef IFETCH_LOADER_EN
        if (load_done) begin
          w_state_nxt = S_RUN;
        end
`else
        w_state_nxt = S_RUN;
`endif
      end
      S_FETCH, S_END: begin
        if (redirect_valid) begin
          w_state_nxt = (redirect_pc < W_MEM_SIZE) ? S_FETCH : S_END;
        end else if (w_issue && (w_pc_adv >= W_MEM_SIZE)) begin
          w_state_nxt = S_END;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Fetch pointer and response tracking; redirect outranks stall and issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_rsp_pc    <= '0;
      r_rsp_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc        <= redirect_pc;
      r_rsp_valid <= 1'b0;
    end else if (!w_stall) begin
      if (w_issue) begin
        r_rsp_pc    <= r_pc;
        r_rsp_valid <= 1'b1;
        r_pc        <= w_pc_adv;
      end else begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Output decode: all outputs forced low while reset is held.
  always_comb begin
    load_ready        = 1'b0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_enable        = 1'b0;
    mem_read_address1 = '0;
    mem_read_address2 = '0;
    out_valid         = 1'b0;
    out_pc            = '0;
    out_instr1        = '0;
    out_instr2        = '0;
    out_valid2        = 1'b0;
    if (!reset) begin
`ifdef IFETCH_LOADER_EN
      load_ready       = w_load_room;
      mem_write_enable = w_load_acc;
      if (w_load_acc) begin
        mem_write_address = 32'(r_load_cnt);
        mem_write_data    = load_data;
      end
`endif
      mem_enable = w_issue;
      if (w_issue) begin
        mem_read_address1 = r_pc;
        mem_read_address2 = w_pc_next;
      end
      out_valid  = w_running && r_rsp_valid;
      out_pc     = r_rsp_pc;
      out_instr1 = mem_instruction1;
      out_instr2 = mem_instruction2;
      out_valid2 = (r_rsp_pc + 32'd1) < W_MEM_SIZE;
    end
  end

endmodule
